// File: rtl/hex_scan_display_if.sv
// rtl/hex_scan_display_if.sv - button/switch inputs and display outputs of the hex scan display
interface hex_scan_display_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   btn;
    logic                dir;
    logic                load;
    logic [4*DIGITS-1:0] load_data;
    logic                blank_lz;
    logic [DIGITS-1:0]   points;
    logic [DIGITS-1:0]   LEs;
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   AN;
    logic [7:0]          SEGMENT;

    modport master (
        output btn, dir, load, load_data, blank_lz, points, LEs,
        input  num, AN, SEGMENT
    );

    modport slave (
        input  btn, dir, load, load_data, blank_lz, points, LEs,
        output num, AN, SEGMENT
    );
endinterface

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - per-digit debounced hex editor with multiplexed common-anode 7-seg scan
module hex_scan_display #(
    parameter int          DIGITS     = 4,
    parameter int          SCAN_BITS  = 17,
    parameter int          DEB_BITS   = 16,
    parameter logic [31:0] INIT_VALUE = 32'hABCD
) (
    input  logic          clk,
    input  logic          rst,
    hex_scan_display_if.slave bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // last count value before a new level is accepted (DEB_MAX-1)
    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'((64'd1 << DEB_BITS) - 64'd2);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIGITS-1:0]   sync1_q, sync2_q, stable_q, stable_d, stable_prev_q;
    logic [DEB_BITS-1:0] cnt_q [DIGITS];
    logic [DEB_BITS-1:0] cnt_d [DIGITS];
    logic [DIGITS-1:0]   press;
    logic [W-1:0]        num_q, num_d;
    logic [SCAN_BITS-1:0] presc_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          cur_nib;
    logic                upper_zero;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // load wins over any press in the same cycle; each nibble wraps on its own
    always_comb begin
        num_d = num_q;
        if (bus.load) begin
            num_d = bus.load_data;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (press[i]) begin
                    num_d[4*i +: 4] = bus.dir ? num_q[4*i +: 4] - 4'd1 : num_q[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        cur_nib    = num_q[4*idx_q +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_q) && num_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        an_d     = ~(DIGITS'(1) << idx_q);
        seg_d[7] = ~bus.points[idx_q];
        if (bus.LEs[idx_q] || (bus.blank_lz && idx_q != '0 && upper_zero)) begin
            seg_d[6:0] = 7'h7F;
        end else begin
            seg_d[6:0] = seg_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < DIGITS; i++) cnt_q[i] <= '0;
            num_q         <= INIT_VALUE[W-1:0];
            presc_q       <= '0;
            idx_q         <= '0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
        end else begin
            sync1_q       <= bus.btn;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < DIGITS; i++) cnt_q[i] <= cnt_d[i];
            num_q         <= num_d;
            presc_q       <= presc_q + 1'b1;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.num     = num_q;
    assign bus.AN      = an_q;
    assign bus.SEGMENT = seg_q;
endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Parametrised successor to the 4-digit button-counter / seven-segment scanner.
- Holds a DIGITS-nibble hex value and edits it per digit with debounced buttons (increment or decrement), with a parallel load path.
- Time-multiplexes the value onto a common-anode seven-segment display, with per-digit blanking, decimal points and leading-zero suppression.
- Sits between the board pins (clk, buttons, switches) and the AN/SEGMENT pins.

Parameters:
- DIGITS, 4: number of digits and buttons, 1..8.
- SCAN_BITS, 17: prescaler width; the scan advances one digit every 2^SCAN_BITS cycles.
- DEB_BITS, 16: debounce counter width; DEB_MAX = 2^DEB_BITS-1.
- INIT_VALUE, 'hABCD: reset value of num, truncated or zero-extended to 4*DIGITS bits.

Ports:
- clk  in  1: the only clock; all logic on posedge.
- rst  in  1: reset, asynchronous and active-high.
- btn  in  DIGITS: raw asynchronous push buttons, active-high; btn[i] edits nibble i.
- dir  in  1: 0 = increment on press, 1 = decrement on press.
- load  in  1: synchronous parallel load strobe.
- load_data  in  4*DIGITS: value loaded when load=1.
- blank_lz  in  1: 1 enables leading-zero suppression.
- points  in  DIGITS: 1 lights the decimal point of digit i.
- LEs  in  DIGITS: 1 blanks segments a-g of digit i.
- num  out  4*DIGITS: current value; nibble i = num[4i+3:4i]; nibble DIGITS-1 is most significant.
- AN  out  DIGITS: digit enables, active-low, one-hot.
- SEGMENT  out  8: {p,g,f,e,d,c,b,a}, active-low.

Behaviour:
Reset (async, while rst=1):
- num = INIT_VALUE; prescaler = 0; digit index idx = 0.
- Synchronisers, stable states and debounce counters all cleared to 0.
- AN = all ones; SEGMENT = 8'hFF.

Button path, per bit, independent:
- 2-flop synchroniser, then debounce counter cnt.
- If synced == stable: cnt <= 0.
- Else if cnt == DEB_MAX-1: stable <= synced, cnt <= 0.
- Else: cnt <= cnt+1.
- Any bounce back to the stable level restarts the count.
- Press pulse = stable & ~stable_q, one cycle; releases produce nothing.
- Latency: nibble changes on exactly the (DEB_MAX+3)th rising edge, counting the first edge that samples btn=1.
- Holding a button gives exactly one press.

Update rule:
- Each pulsed nibble becomes nibble+1 (dir=0) or nibble-1 (dir=1), mod 16.
- Wrap: F->0 on increment, 0->F on decrement; no carry or borrow into neighbouring nibbles.
- Simultaneous pulses on different bits all apply on the same edge.
- dir is sampled on the update edge.
- load=1 has priority: num <= load_data, and press pulses in that cycle are discarded.

Scan:
- Prescaler counts freely.
- When prescaler == all ones, idx <= (idx == DIGITS-1) ? 0 : idx+1. Non-power-of-2 DIGITS wraps correctly.
- AN and SEGMENT are registered and updated every cycle from the current idx, num, points, LEs and blank_lz, so they lag inputs by one cycle.
- AN = ~(1 << idx).

Segment decode, {a,b,c,d,e,f,g} for nibble 0..F:
- 0-7: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
- 8-F: 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000

Blanking:
- Digit idx is blanked (a-g = 1) if LEs[idx] = 1.
- It is also blanked if blank_lz = 1, idx != 0, and nibbles idx..DIGITS-1 are all zero.
- Digit 0 is never zero-suppressed.
- SEGMENT[7] = ~points[idx], independent of blanking.

Reset mid-operation:
- Everything clears immediately, including any partially debounced press.
- A button held through reset release is treated as a new press once debounced.

Test Plan (DIGITS=4, SCAN_BITS=2, DEB_BITS=2 so DEB_MAX=3, INIT_VALUE='hABCD):
- Reset, then run 32 cycles -> num=ABCD; AN cycles 1110, 1101, 1011, 0111, each held 4 cycles, 1 cycle after idx changes; SEGMENT[6:0] shows D, C, B, A patterns.
- btn[0] held high 20 cycles -> num=ABCE exactly on the 6th edge after the first sampling edge, no further change; with dir=1 a second press gives ABCD.
- btn[3] toggling 1,1,0,1,1,0... (never 3 stable cycles) -> num unchanged; then held high -> B BCD... i.e. num=BBCD once.
- load with load_data=0x00F0, blank_lz=1 -> num=00F0; digits 3 and 2 show a-g off; digit 1 shows F; digit 0 shows 0; blank_lz=0 -> all four digits lit.
- num=F000: press btn[3] with dir=0 -> 0000 (no carry); press btn[0] with dir=1 -> 000F; press btn[1] and btn[2] on the same cycle -> both nibbles change on the same edge.
- Assert rst mid-debounce and mid-scan -> AN=1111, SEGMENT=FF, num=ABCD immediately; points=4'b0101, LEs=4'b0010 after release -> dp lit on digits 0 and 2, digit 1 blanked.
